// File: rtl/traffic_light_ctrl_multi_pkg.sv
// traffic_pkg: shared state encoding, lamp codes and flash timing for the
// multi-direction traffic light controller.
// Optional feature macro: TRAFFIC_FLASH_MODE_EN (adds the S_FLASH state).
package traffic_pkg;

`ifdef TRAFFIC_FLASH_MODE_EN
   typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW, S_FLASH} state_e;
`else
   typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW} state_e;
`endif

   // Lamp codes, {red,yellow,green}
   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;
   localparam logic [2:0] LT_OFF = 3'b000;

   // Cycles per half period of the flashing-yellow pattern
   localparam int FLASH_HALF = 8;

endpackage

// File: rtl/traffic_light_ctrl_multi_rr_next_dir.sv
// rr_next_dir: combinational wrap-around search for the next direction with
// demand, starting at phase+1 and ending at phase itself.
module rr_next_dir #(
   parameter int NUM_DIR = 4,
   parameter int PW      = $clog2(NUM_DIR)
) (
   input  logic [NUM_DIR-1:0] demand,
   input  logic [PW-1:0]      phase,
   output logic               valid,
   output logic [PW-1:0]      next_idx
);

   // First demanding direction after phase; phase itself is checked last
   always_comb begin
      int idx;
      idx      = 0;
      valid    = 1'b0;
      next_idx = phase;
      for (int k = 1; k <= NUM_DIR; k++) begin
         idx = (int'(phase) + k) % NUM_DIR;
         if (!valid && demand[idx]) begin
            valid    = 1'b1;
            next_idx = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/traffic_light_ctrl_multi.sv
// traffic_light_ctrl_multi: round-robin demand-driven signal controller for
// NUM_DIR approaches with green extension, all-red clearance and
// rest-in-red. All outputs are registered and update with the state.
// Optional feature macro: TRAFFIC_FLASH_MODE_EN (flash input, flashing yellow).
module traffic_light_ctrl_multi
   import traffic_pkg::*;
#(
   parameter int NUM_DIR    = 4,
   parameter int GREEN_CYC  = 20,
   parameter int YELLOW_CYC = 4,
   parameter int ALLRED_CYC = 2,
   parameter int MAX_EXT    = 10,
   parameter int CNT_W      = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_DIR-1:0]         demand,
`ifdef TRAFFIC_FLASH_MODE_EN
   input  logic                       flash,
`endif
   output logic [3*NUM_DIR-1:0]       light,
   output logic                       on,
   output logic [$clog2(NUM_DIR)-1:0] phase
);

   localparam int PW = $clog2(NUM_DIR);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     timer_q, timer_d;
   logic [CNT_W-1:0]     ext_q, ext_d;
   logic [PW-1:0]        phase_q, phase_d;
   logic [3*NUM_DIR-1:0] light_q, light_d;
   logic                 on_q, on_d;
   logic [NUM_DIR-1:0]   others;
   logic                 rr_vld;
   logic [PW-1:0]        rr_nxt;
`ifdef TRAFFIC_FLASH_MODE_EN
   logic                 blink_q, blink_d;
`endif

   rr_next_dir #(.NUM_DIR(NUM_DIR), .PW(PW)) u_rr (
      .demand   (demand),
      .phase    (phase_q),
      .valid    (rr_vld),
      .next_idx (rr_nxt)
   );

   // Next-state, timer, phase and extension bookkeeping
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      ext_d   = ext_q;
      phase_d = phase_q;
      others  = demand;
      others[phase_q] = 1'b0;
`ifdef TRAFFIC_FLASH_MODE_EN
      blink_d = blink_q;
`endif
      if (timer_q != '0) timer_d = timer_q - CNT_W'(1);
      case (state_q)
         S_ALLRED: begin
            // timer stays 0 while resting in red with no demand
            if (timer_q == '0 && rr_vld) begin
               state_d = S_GREEN;
               phase_d = rr_nxt;
               ext_d   = '0;
               timer_d = CNT_W'(GREEN_CYC - 1);
            end
         end
         S_GREEN: begin
            if (timer_q == '0) begin
               // extend only when this approach is the sole demand
               if (demand[phase_q] && others == '0 && ext_q < CNT_W'(MAX_EXT)) begin
                  ext_d = ext_q + CNT_W'(1);
               end else begin
                  state_d = S_YELLOW;
                  timer_d = CNT_W'(YELLOW_CYC - 1);
               end
            end
         end
         S_YELLOW: begin
            if (timer_q == '0) begin
               state_d = S_ALLRED;
               timer_d = CNT_W'(ALLRED_CYC - 1);
            end
         end
`ifdef TRAFFIC_FLASH_MODE_EN
         S_FLASH: begin
            if (timer_q == '0) begin
               timer_d = CNT_W'(FLASH_HALF - 1);
               blink_d = ~blink_q;
            end
         end
`endif
         default: ;
      endcase
`ifdef TRAFFIC_FLASH_MODE_EN
      // flash overrides the normal sequence; leaving it restarts clearance
      if (flash) begin
         if (state_q != S_FLASH) begin
            state_d = S_FLASH;
            timer_d = CNT_W'(FLASH_HALF - 1);
            blink_d = 1'b1;
         end
      end else if (state_q == S_FLASH) begin
         state_d = S_ALLRED;
         timer_d = CNT_W'(ALLRED_CYC - 1);
      end
`endif
   end

   // Lamp pattern derived from the next state so lamps and state move together
   always_comb begin
      on_d = 1'b0;
      for (int i = 0; i < NUM_DIR; i++) light_d[3*i +: 3] = LT_RED;
      case (state_d)
         S_GREEN: begin
            light_d[3*int'(phase_d) +: 3] = LT_GRN;
            on_d = 1'b1;
         end
         S_YELLOW: begin
            light_d[3*int'(phase_d) +: 3] = LT_YEL;
            on_d = 1'b1;
         end
`ifdef TRAFFIC_FLASH_MODE_EN
         S_FLASH: begin
            for (int i = 0; i < NUM_DIR; i++) light_d[3*i +: 3] = blink_d ? LT_YEL : LT_OFF;
         end
`endif
         default: ;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_ALLRED;
         timer_q <= CNT_W'(ALLRED_CYC - 1);
         ext_q   <= '0;
         phase_q <= PW'(NUM_DIR - 1);
         light_q <= {NUM_DIR{LT_RED}};
         on_q    <= 1'b0;
`ifdef TRAFFIC_FLASH_MODE_EN
         blink_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         ext_q   <= ext_d;
         phase_q <= phase_d;
         light_q <= light_d;
         on_q    <= on_d;
`ifdef TRAFFIC_FLASH_MODE_EN
         blink_q <= blink_d;
`endif
      end
   end

   assign light = light_q;
   assign on    = on_q;
   assign phase = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl_multi.sv
// Bench for traffic_light_ctrl_multi: directed scenarios plus random demand,
// every cycle compared against a duration-based reference model.
module tb_traffic_light_ctrl_multi;

   localparam int N      = 4;
   localparam int GREEN  = 20;
   localparam int YELLOW = 4;
   localparam int ALLRED = 2;
   localparam int MAXEXT = 10;
   localparam int FH     = 8;
   localparam logic [3*N-1:0] GMASK   = {N{3'b001}};
   localparam logic [3*N-1:0] ALL_RED = 12'b100_100_100_100;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   demand = '0;
   logic           flash = 1'b0;
   logic [3*N-1:0] light;
   logic           on;
   logic [1:0]     phase;

   int n_vec = 0;
   int n_err = 0;

   // model: mode 0 = clearance red, 1 = green, 2 = yellow, 3 = flashing
   int m_mode = 0;
   int m_age  = 1;
   int m_ph   = N - 1;
   int m_fage = 0;

   logic g_now = 1'b0, g_start = 1'b0;

   traffic_light_ctrl_multi #(
      .NUM_DIR(N), .GREEN_CYC(GREEN), .YELLOW_CYC(YELLOW),
      .ALLRED_CYC(ALLRED), .MAX_EXT(MAXEXT), .CNT_W(8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .demand (demand),
`ifdef TRAFFIC_FLASH_MODE_EN
      .flash  (flash),
`endif
      .light  (light),
      .on     (on),
      .phase  (phase)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3*N-1:0] m_light();
      logic [3*N-1:0] r;
      for (int i = 0; i < N; i++) r[3*i +: 3] = 3'b100;
      if (m_mode == 1) r[3*m_ph +: 3] = 3'b001;
      if (m_mode == 2) r[3*m_ph +: 3] = 3'b010;
      if (m_mode == 3)
         for (int i = 0; i < N; i++) r[3*i +: 3] = ((m_fage / FH) % 2 == 0) ? 3'b010 : 3'b000;
      return r;
   endfunction

   // advance the model by one clock using the inputs seen at that edge
   task automatic model_step();
      int d;
      bit found;
      if (rst) begin
         m_mode = 0; m_age = 1; m_ph = N - 1;
      end else if (flash) begin
         if (m_mode != 3) begin m_mode = 3; m_fage = 0; end
         else m_fage++;
      end else if (m_mode == 3) begin
         m_mode = 0; m_age = 1;
      end else if (m_mode == 0) begin
         found = 0;
         if (m_age >= ALLRED)
            for (int k = 1; k <= N; k++) begin
               d = (m_ph + k) % N;
               if (!found && demand[d]) begin found = 1; m_ph = d; end
            end
         if (found) begin m_mode = 1; m_age = 1; end
         else m_age++;
      end else if (m_mode == 1) begin
         if (m_age < GREEN) m_age++;
         else if (demand == N'(1 << m_ph) && m_age < GREEN + MAXEXT) m_age++;
         else begin m_mode = 2; m_age = 1; end
      end else begin
         if (m_age < YELLOW) m_age++;
         else begin m_mode = 0; m_age = 1; end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("light", 32'(light), 32'(m_light()));
      chk("on", 32'(on), 32'((m_mode == 1 || m_mode == 2) ? 1 : 0));
      chk("phase", 32'(phase), 32'(m_ph));
      g_start = (|(light & GMASK)) && !g_now;
      g_now   = |(light & GMASK);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   task automatic wait_gstart(output int n);
      n = 0;
      do begin tick(); n++; end while (!g_start && n < 600);
      if (!g_start) chk("gstart_timeout", 0, 1);
   endtask

   task automatic green_len(output int n);
      n = 1;
      while (g_now && n < 1000) begin
         tick();
         if (g_now) n++;
      end
   endtask

   initial begin
      int n, len, gap;
      // 1: reset and idle rest-in-red
      do_reset(2);
      chk("rst_light", 32'(light), 32'(ALL_RED));
      chk("rst_on", 32'(on), 0);
      chk("rst_phase", 32'(phase), 3);
      repeat (100) tick();
      chk("idle_light", 32'(light), 32'(ALL_RED));

      // 2: single demand extends to the maximum and re-serves itself
      do_reset(2);
      demand = 4'b0001;
      wait_gstart(n);
      chk("allred_len", n, 2);
      green_len(len);
      chk("ext_green_len", len, GREEN + MAXEXT);
      wait_gstart(gap);
      chk("self_gap", gap, 6);
      chk("self_phase", 32'(phase), 0);

      // 3: full demand, strict rotation, no extension
      do_reset(2);
      demand = 4'b1111;
      wait_gstart(n);
      for (int k = 0; k < 5; k++) begin
         chk("rr_order", 32'(phase), k % N);
         green_len(len);
         chk("rr_green_len", len, GREEN);
         if (k < 4) begin
            wait_gstart(gap);
            chk("rr_period", len + gap, 26);
         end
      end

      // 4: competing demand ends an extension
      do_reset(2);
      demand = 4'b0100;
      wait_gstart(n);
      n = 1;
      while (n < 24) begin tick(); n++; end
      demand = 4'b0110;
      tick();
      chk("cut_yellow", 32'(light), 32'(12'b100_010_100_100));
      wait_gstart(gap);
      chk("cut_gap", gap, 6);
      chk("cut_phase", 32'(phase), 1);

      // 5: reset during yellow
      do_reset(2);
      demand = 4'b0100;
      n = 0;
      do begin tick(); n++; end while (light !== 12'b100_010_100_100 && n < 500);
      chk("yel_reached", 32'(light), 32'(12'b100_010_100_100));
      do_reset(1);
      chk("midrst_light", 32'(light), 32'(ALL_RED));
      chk("midrst_on", 32'(on), 0);
      chk("midrst_phase", 32'(phase), 3);
      wait_gstart(n);
      chk("midrst_allred", n, 2);
      chk("midrst_dir", 32'(phase), 2);

`ifdef TRAFFIC_FLASH_MODE_EN
      // 6: flashing yellow and return to clearance
      do_reset(2);
      demand = 4'b0110;
      wait_gstart(n);
      repeat (3) tick();
      flash = 1'b1;
      tick();
      chk("flash_yel", 32'(light), 32'(12'b010_010_010_010));
      chk("flash_on", 32'(on), 0);
      repeat (FH) tick();
      chk("flash_off", 32'(light), 0);
      repeat (FH) tick();
      chk("flash_yel2", 32'(light), 32'(12'b010_010_010_010));
      flash = 1'b0;
      tick();
      chk("flash_exit", 32'(light), 32'(ALL_RED));
      wait_gstart(n);
      chk("flash_allred", n, 2);
      chk("flash_resume", 32'(phase), 2);
`endif

      // 7: random demand patterns with occasional reset / flash
      for (int s = 0; s < 40; s++) begin
         demand = N'($urandom);
         if ($urandom_range(7) == 0) rst = 1'b1;
`ifdef TRAFFIC_FLASH_MODE_EN
         flash = ($urandom_range(5) == 0);
`endif
         tick();
         rst = 1'b0;
         repeat ($urandom_range(150, 1)) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
